fetch_unit: RTL



---
 rtl/riscv_core_pkg.sv | 21 ++
 rtl/next_pc_logic.sv | 24 ++
 rtl/fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// Shared constants and fetch-stage state encodings for the RV32I core.
// The S_FAULT state only exists when MISALIGN_TRAP_EN is defined.
package riscv_core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } fetch_state_t;
`endif

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: Pc + 4 adder, taken-branch mux and target alignment.
// MISALIGN_TRAP_EN: pass the raw target through and flag misalignment; otherwise force-align it.
module next_pc_logic (
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  assign pc_plus4 = pc + 32'd4;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = pc_src && (pc_target[1:0] != 2'b00);
  assign next_pc    = pc_src ? pc_target : pc_plus4;
`else
  assign next_pc    = pc_src ? (pc_target & ~32'h0000_0003) : pc_plus4;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds Pc, fetches over a req/ack port and waits for Retire.
// Optional MISALIGN_TRAP_EN halts in S_FAULT on a misaligned taken target.
//
// state   | meaning
// S_FETCH | IMem request outstanding at Pc
// S_EXEC  | Instr held, waiting for Retire
// S_FAULT | halted after misaligned target (MISALIGN_TRAP_EN only)
module fetch_unit
  import riscv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PcSrc,
  input  logic [31:0] PcTarget,
  input  logic        Retire,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_RData,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic [31:0] Pc,
  output logic [31:0] PcPlus4,
  output logic        Fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic [31:0]  next_pc;
`ifdef MISALIGN_TRAP_EN
  logic         misaligned;
  logic         fault_q, fault_d;
`endif

  next_pc_logic u_next_pc (
    .pc        (pc_q),
    .pc_src    (PcSrc),
    .pc_target (PcTarget),
    .pc_plus4  (PcPlus4),
    .next_pc   (next_pc)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned(misaligned)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
`ifdef MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
`ifdef MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
`ifdef MISALIGN_TRAP_EN
    fault_d = fault_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (IMem_Ack) begin
          state_d = S_EXEC;
          instr_d = IMem_RData;
          valid_d = 1'b1;
          req_d   = 1'b0;
        end
      end
      S_EXEC: begin
        if (Retire) begin
          state_d = S_FETCH;
          pc_d    = next_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          req_d   = 1'b1;
`ifdef MISALIGN_TRAP_EN
          // Pc still takes the bad target so software can see where it jumped
          if (misaligned) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            req_d   = 1'b0;
          end
`endif
        end
      end
`ifdef MISALIGN_TRAP_EN
      S_FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
`endif
      default: begin
        state_d = S_FETCH;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        req_d   = 1'b1;
      end
    endcase
  end

  assign IMem_Req    = req_q;
  assign IMem_Addr   = pc_q;
  assign Pc          = pc_q;
  assign Instr       = instr_q;
  assign Instr_Valid = valid_q;
`ifdef MISALIGN_TRAP_EN
  assign Fault       = fault_q;
`else
  assign Fault       = 1'b0;
`endif

endmodule
